// File: rtl/bin_load_ctrl.sv
// Loads one bin (clauses, var/lvl states) from the store into sat_engine, runs the core,
// then writes the clause array and state lists back; start_core_o at NUM_CLAUSES+4 after start.
module bin_load_ctrl #(
    parameter int NUM_CLAUSES      = 8,
    parameter int NUM_VARS         = 8,
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_CIDX       = 3,
    parameter int WIDTH_BIN_ID     = 10,
    parameter int WIDTH_LVL        = 16,
    parameter int WIDTH_VAR_STATES = 19,
    parameter int WIDTH_LVL_STATES = 11
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start_bin_i,
    input  logic [WIDTH_BIN_ID-1:0]                bin_id_i,
    input  logic [WIDTH_LVL-1:0]                   load_lvl_i,
    input  logic [WIDTH_LVL-1:0]                   base_lvl_i,
    output logic                                   busy_o,
    output logic                                   done_bin_o,
    output logic                                   bin_sat_o,
    output logic                                   bin_unsat_o,
    output logic [WIDTH_LVL-1:0]                   bkt_lvl_o,
    output logic [WIDTH_BIN_ID-1:0]                bkt_bin_o,
    output logic                                   cmem_rd_o,
    output logic                                   cmem_wr_o,
    output logic [WIDTH_BIN_ID+WIDTH_CIDX-1:0]     cmem_addr_o,
    input  logic [2*NUM_VARS-1:0]                  cmem_rdata_i,
    output logic [2*NUM_VARS-1:0]                  cmem_wdata_o,
    output logic                                   smem_rd_o,
    output logic                                   smem_wr_o,
    output logic [WIDTH_BIN_ID-1:0]                smem_addr_o,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   smem_vs_rdata_i,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   smem_vs_wdata_o,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   smem_ls_rdata_i,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   smem_ls_wdata_o,
    output logic                                   start_core_o,
    input  logic                                   done_core_i,
    input  logic                                   sat_i,
    input  logic                                   unsat_i,
    input  logic [WIDTH_LVL-1:0]                   bkt_lvl_i,
    input  logic [WIDTH_BIN_ID-1:0]                bkt_bin_i,
    output logic [WIDTH_LVL-1:0]                   cur_bin_num_o,
    output logic [WIDTH_LVL-1:0]                   load_lvl_o,
    output logic [WIDTH_LVL-1:0]                   base_lvl_o,
    output logic [NUM_CLAUSES-1:0]                 wr_carray_o,
    output logic [NUM_CLAUSES-1:0]                 rd_carray_o,
    output logic [2*NUM_VARS-1:0]                  clause_o,
    input  logic [2*NUM_VARS-1:0]                  clause_i,
    output logic [NUM_VARS-1:0]                    wr_var_states_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   var_states_o,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   var_states_i,
    output logic [NUM_LVLS-1:0]                    wr_lvl_states_o,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   lvl_states_o,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   lvl_states_i,
    output logic                                   base_lvl_en_o
);

    localparam int KW = WIDTH_CIDX + 1;
    localparam logic [KW-1:0]          K_ONE  = KW'(1);
    localparam logic [KW-1:0]          K_NUMC = KW'(NUM_CLAUSES);
    localparam logic [KW-1:0]          K_LAST = KW'(NUM_CLAUSES - 1);
    localparam logic [NUM_CLAUSES-1:0] C_ONE  = NUM_CLAUSES'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_LD_C, S_LD_S_RD, S_LD_S_WR, S_START, S_RUN, S_WB_C, S_WB_S, S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [KW-1:0]           r_k;
    logic [WIDTH_BIN_ID-1:0] r_bin_id;
    logic [WIDTH_LVL-1:0]    r_load_lvl;
    logic [WIDTH_LVL-1:0]    r_base_lvl;
    logic                    r_sat;
    logic                    r_unsat;
    logic [WIDTH_LVL-1:0]    r_bkt_lvl;
    logic [WIDTH_BIN_ID-1:0] r_bkt_bin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_bin_id   <= '0;
            r_load_lvl <= '0;
            r_base_lvl <= '0;
            r_sat      <= 1'b0;
            r_unsat    <= 1'b0;
            r_bkt_lvl  <= '0;
            r_bkt_bin  <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (start_bin_i) begin
                        r_bin_id   <= bin_id_i;
                        r_load_lvl <= load_lvl_i;
                        r_base_lvl <= base_lvl_i;
                        r_k        <= '0;
                    end
                end
                S_LD_C: r_k <= r_k + K_ONE;
                S_RUN: begin
                    // Verdict survives until the next core completion, not the next start.
                    if (done_core_i) begin
                        r_sat     <= sat_i;
                        r_unsat   <= unsat_i;
                        r_bkt_lvl <= bkt_lvl_i;
                        r_bkt_bin <= bkt_bin_i;
                        r_k       <= '0;
                    end
                end
                S_WB_C: r_k <= r_k + K_ONE;
                default: ;
            endcase
        end
    end

    assign busy_o        = (r_state != S_IDLE);
    assign bin_sat_o     = r_sat;
    assign bin_unsat_o   = r_unsat;
    assign bkt_lvl_o     = r_bkt_lvl;
    assign bkt_bin_o     = r_bkt_bin;
    assign cur_bin_num_o = WIDTH_LVL'(r_bin_id);
    assign load_lvl_o    = r_load_lvl;
    assign base_lvl_o    = r_base_lvl;

    always_comb begin
        w_next_state    = r_state;
        done_bin_o      = 1'b0;
        cmem_rd_o       = 1'b0;
        cmem_wr_o       = 1'b0;
        cmem_addr_o     = '0;
        cmem_wdata_o    = '0;
        smem_rd_o       = 1'b0;
        smem_wr_o       = 1'b0;
        smem_addr_o     = '0;
        smem_vs_wdata_o = '0;
        smem_ls_wdata_o = '0;
        start_core_o    = 1'b0;
        wr_carray_o     = '0;
        rd_carray_o     = '0;
        clause_o        = '0;
        wr_var_states_o = '0;
        var_states_o    = '0;
        wr_lvl_states_o = '0;
        lvl_states_o    = '0;
        base_lvl_en_o   = 1'b0;
        case (r_state)
            S_IDLE: if (start_bin_i) w_next_state = S_LD_C;
            S_LD_C: begin
                // Read of row k overlaps the engine write of row k-1 (1-cycle store latency).
                if (r_k < K_NUMC) begin
                    cmem_rd_o   = 1'b1;
                    cmem_addr_o = {r_bin_id, r_k[WIDTH_CIDX-1:0]};
                end
                if (r_k != '0) begin
                    wr_carray_o = C_ONE << (r_k - K_ONE);
                    clause_o    = cmem_rdata_i;
                end
                if (r_k == K_NUMC) w_next_state = S_LD_S_RD;
            end
            S_LD_S_RD: begin
                smem_rd_o    = 1'b1;
                smem_addr_o  = r_bin_id;
                w_next_state = S_LD_S_WR;
            end
            S_LD_S_WR: begin
                wr_var_states_o = '1;
                wr_lvl_states_o = '1;
                var_states_o    = smem_vs_rdata_i;
                lvl_states_o    = smem_ls_rdata_i;
                base_lvl_en_o   = 1'b1;
                w_next_state    = S_START;
            end
            S_START: begin
                start_core_o = 1'b1;
                w_next_state = S_RUN;
            end
            S_RUN: if (done_core_i) w_next_state = S_WB_C;
            S_WB_C: begin
                rd_carray_o  = C_ONE << r_k;
                cmem_wr_o    = 1'b1;
                cmem_addr_o  = {r_bin_id, r_k[WIDTH_CIDX-1:0]};
                cmem_wdata_o = clause_i;
                if (r_k == K_LAST) w_next_state = S_WB_S;
            end
            S_WB_S: begin
                smem_wr_o       = 1'b1;
                smem_addr_o     = r_bin_id;
                smem_vs_wdata_o = var_states_i;
                smem_ls_wdata_o = lvl_states_i;
                w_next_state    = S_DONE;
            end
            S_DONE: begin
                done_bin_o   = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bin_load_ctrl.sv
// Bench for bin_load_ctrl: store/engine models, a timed event scoreboard, and a table of bins.
module tb_bin_load_ctrl;

    localparam int K_RD = 0, K_WRC = 1, K_SRD = 2, K_SWR = 3, K_START = 4, K_WBC = 5, K_WBS = 6, K_DONE = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_bin_i;
    logic [9:0]   bin_id_i;
    logic [15:0]  load_lvl_i, base_lvl_i;
    logic         busy_o, done_bin_o, bin_sat_o, bin_unsat_o;
    logic [15:0]  bkt_lvl_o;
    logic [9:0]   bkt_bin_o;
    logic         cmem_rd_o, cmem_wr_o;
    logic [12:0]  cmem_addr_o;
    logic [15:0]  cmem_rdata_i, cmem_wdata_o;
    logic         smem_rd_o, smem_wr_o;
    logic [9:0]   smem_addr_o;
    logic [151:0] smem_vs_rdata_i, smem_vs_wdata_o;
    logic [87:0]  smem_ls_rdata_i, smem_ls_wdata_o;
    logic         start_core_o, done_core_i, sat_i, unsat_i;
    logic [15:0]  bkt_lvl_i;
    logic [9:0]   bkt_bin_i;
    logic [15:0]  cur_bin_num_o, load_lvl_o, base_lvl_o;
    logic [7:0]   wr_carray_o, rd_carray_o;
    logic [15:0]  clause_o, clause_i;
    logic [7:0]   wr_var_states_o;
    logic [151:0] var_states_o, var_states_i;
    logic [7:0]   wr_lvl_states_o;
    logic [87:0]  lvl_states_o, lvl_states_i;
    logic         base_lvl_en_o;

    bin_load_ctrl dut (
        .clk(clk), .rst(rst), .start_bin_i(start_bin_i), .bin_id_i(bin_id_i),
        .load_lvl_i(load_lvl_i), .base_lvl_i(base_lvl_i), .busy_o(busy_o),
        .done_bin_o(done_bin_o), .bin_sat_o(bin_sat_o), .bin_unsat_o(bin_unsat_o),
        .bkt_lvl_o(bkt_lvl_o), .bkt_bin_o(bkt_bin_o), .cmem_rd_o(cmem_rd_o),
        .cmem_wr_o(cmem_wr_o), .cmem_addr_o(cmem_addr_o), .cmem_rdata_i(cmem_rdata_i),
        .cmem_wdata_o(cmem_wdata_o), .smem_rd_o(smem_rd_o), .smem_wr_o(smem_wr_o),
        .smem_addr_o(smem_addr_o), .smem_vs_rdata_i(smem_vs_rdata_i),
        .smem_vs_wdata_o(smem_vs_wdata_o), .smem_ls_rdata_i(smem_ls_rdata_i),
        .smem_ls_wdata_o(smem_ls_wdata_o), .start_core_o(start_core_o),
        .done_core_i(done_core_i), .sat_i(sat_i), .unsat_i(unsat_i),
        .bkt_lvl_i(bkt_lvl_i), .bkt_bin_i(bkt_bin_i), .cur_bin_num_o(cur_bin_num_o),
        .load_lvl_o(load_lvl_o), .base_lvl_o(base_lvl_o), .wr_carray_o(wr_carray_o),
        .rd_carray_o(rd_carray_o), .clause_o(clause_o), .clause_i(clause_i),
        .wr_var_states_o(wr_var_states_o), .var_states_o(var_states_o),
        .var_states_i(var_states_i), .wr_lvl_states_o(wr_lvl_states_o),
        .lvl_states_o(lvl_states_o), .lvl_states_i(lvl_states_i),
        .base_lvl_en_o(base_lvl_en_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Store and engine models; the engine returns what it was loaded with XOR a per-run mask.
    logic [15:0]  cmem_m [0:8191];
    logic [151:0] svs_m  [0:1023];
    logic [87:0]  sls_m  [0:1023];
    logic [15:0]  eng_c  [0:7];
    logic [151:0] eng_vs, vs_mask;
    logic [87:0]  eng_ls, ls_mask;
    logic [15:0]  cmask  [0:7];

    always @(posedge clk) begin
        if (cmem_rd_o) cmem_rdata_i <= cmem_m[cmem_addr_o];
        if (smem_rd_o) begin
            smem_vs_rdata_i <= svs_m[smem_addr_o];
            smem_ls_rdata_i <= sls_m[smem_addr_o];
        end
        for (int i = 0; i < 8; i++) if (wr_carray_o[i]) eng_c[i] <= clause_o;
        if (wr_var_states_o != 8'h0) eng_vs <= var_states_o;
        if (wr_lvl_states_o != 8'h0) eng_ls <= lvl_states_o;
    end

    always_comb begin
        clause_i = '0;
        for (int i = 0; i < 8; i++) if (rd_carray_o[i]) clause_i = eng_c[i] ^ cmask[i];
    end
    assign var_states_i = eng_vs ^ vs_mask;
    assign lvl_states_i = eng_ls ^ ls_mask;

    logic any_out;
    assign any_out = |{busy_o, done_bin_o, bin_sat_o, bin_unsat_o, bkt_lvl_o, bkt_bin_o,
                       cmem_rd_o, cmem_wr_o, cmem_addr_o, cmem_wdata_o, smem_rd_o, smem_wr_o,
                       smem_addr_o, smem_vs_wdata_o, smem_ls_wdata_o, start_core_o,
                       cur_bin_num_o, load_lvl_o, base_lvl_o, wr_carray_o, rd_carray_o,
                       clause_o, wr_var_states_o, var_states_o, wr_lvl_states_o,
                       lvl_states_o, base_lvl_en_o};

    typedef struct {
        int            kind;
        int            cyc;
        logic [63:0]   a;
        logic [255:0]  d;
    } ev_t;
    ev_t sb[$];

    typedef struct {
        logic [9:0]  bin;
        logic [15:0] ld;
        logic [15:0] bs;
        logic        sat;
        logic        unsat;
        logic [15:0] blvl;
        logic [9:0]  bbin;
        int          wait_n;
        logic        done_in_ldc;
        logic        start_in_run;
        logic        rst_wb;
    } vec_t;
    vec_t vecs[6];

    logic        exp_sat, exp_unsat;
    logic [15:0] exp_blvl;
    logic [9:0]  exp_bbin;

    function automatic string kname(input int k);
        case (k)
            K_RD:    return "cmem_rd";
            K_WRC:   return "wr_carray";
            K_SRD:   return "smem_rd";
            K_SWR:   return "state_load";
            K_START: return "start_core";
            K_WBC:   return "wb_clause";
            K_WBS:   return "smem_wr";
            default: return "done_bin";
        endcase
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int c, input logic [63:0] a, input logic [255:0] d);
        ev_t e;
        e.kind = kind; e.cyc = c; e.a = a; e.d = d;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input logic [63:0] a, input logic [255:0] d);
        ev_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_%s cyc=%0d actual=%0h expected=none", kname(kind), cyc, a);
            return;
        end
        e = sb.pop_front();
        check({kname(kind), "_kind"}, 256'(kind), 256'(e.kind));
        check({kname(kind), "_cycle"}, 256'(cyc), 256'(e.cyc));
        check({kname(kind), "_addr"}, 256'(a), 256'(e.a));
        check({kname(kind), "_data"}, d, e.d);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (cmem_rd_o)          pop_cmp(K_RD, 64'(cmem_addr_o), '0);
                if (wr_carray_o != 0)   pop_cmp(K_WRC, 64'(wr_carray_o), 256'(clause_o));
                if (smem_rd_o)          pop_cmp(K_SRD, 64'(smem_addr_o), '0);
                if (wr_var_states_o != 0 || wr_lvl_states_o != 0 || base_lvl_en_o)
                    pop_cmp(K_SWR, 64'({wr_var_states_o, wr_lvl_states_o, base_lvl_en_o}),
                            256'({lvl_states_o, var_states_o}));
                if (start_core_o)       pop_cmp(K_START, 64'({cur_bin_num_o, load_lvl_o, base_lvl_o}), '0);
                if (cmem_wr_o || rd_carray_o != 0)
                    pop_cmp(K_WBC, 64'({rd_carray_o, cmem_addr_o}), 256'(cmem_wdata_o));
                if (smem_wr_o)          pop_cmp(K_WBS, 64'(smem_addr_o), 256'({smem_ls_wdata_o, smem_vs_wdata_o}));
                if (done_bin_o)         pop_cmp(K_DONE, '0, '0);
            end
        end
    end

    task automatic check_latched(input string tag);
        check({tag, "_bin_sat"}, 256'(bin_sat_o), 256'(exp_sat));
        check({tag, "_bin_unsat"}, 256'(bin_unsat_o), 256'(exp_unsat));
        check({tag, "_bkt_lvl"}, 256'(bkt_lvl_o), 256'(exp_blvl));
        check({tag, "_bkt_bin"}, 256'(bkt_bin_o), 256'(exp_bbin));
    endtask

    task automatic run_bin(input vec_t v);
        int s0, d;
        logic [255:0] r;
        logic [12:0]  ad;
        @(negedge clk);
        s0 = cyc;
        for (int k = 0; k < 8; k++) begin
            cmem_m[{v.bin, 3'(k)}] = 16'($urandom);
            cmask[k] = 16'($urandom) | 16'h1;
        end
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        svs_m[v.bin] = r[151:0];
        sls_m[v.bin] = r[255:168];
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        vs_mask = r[151:0];
        ls_mask = r[239:152];
        start_bin_i = 1'b1;
        bin_id_i    = v.bin;
        load_lvl_i  = v.ld;
        base_lvl_i  = v.bs;
        for (int c = 1; c <= 9; c++) begin
            if (c <= 8) begin
                ad = {v.bin, 3'(c - 1)};
                push(K_RD, s0 + c, 64'(ad), '0);
            end
            if (c >= 2) push(K_WRC, s0 + c, 64'(8'h1 << (c - 2)), 256'(cmem_m[{v.bin, 3'(c - 2)}]));
        end
        push(K_SRD, s0 + 10, 64'(v.bin), '0);
        push(K_SWR, s0 + 11, 64'(17'h1ffff), 256'({sls_m[v.bin], svs_m[v.bin]}));
        push(K_START, s0 + 12, 64'({16'(v.bin), v.ld, v.bs}), '0);
        for (int n = 1; n <= 12 + v.wait_n; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start_bin_i = 1'b0;
                bin_id_i    = ~v.bin;
                load_lvl_i  = ~v.ld;
                base_lvl_i  = ~v.bs;
                check("busy_during_load", 256'(busy_o), 256'(1));
            end
            if (n == 4 && v.done_in_ldc) begin
                done_core_i = 1'b1; sat_i = 1'b1; unsat_i = 1'b1;
                bkt_lvl_i = 16'hdead; bkt_bin_i = 10'h1ab;
            end
            if (n == 5) begin
                done_core_i = 1'b0;
                check_latched("held_over_start");
            end
            if (n == 13 && v.start_in_run) begin
                start_bin_i = 1'b1;
                bin_id_i    = v.bin ^ 10'h3;
            end
            if (n == 14) start_bin_i = 1'b0;
        end
        d = cyc;
        done_core_i = 1'b1;
        sat_i = v.sat; unsat_i = v.unsat; bkt_lvl_i = v.blvl; bkt_bin_i = v.bbin;
        for (int k = 0; k < 8; k++) begin
            ad = {v.bin, 3'(k)};
            push(K_WBC, d + 1 + k, 64'({8'h1 << k, ad}), 256'(cmem_m[ad] ^ cmask[k]));
        end
        push(K_WBS, d + 9, 64'(v.bin), 256'({sls_m[v.bin] ^ ls_mask, svs_m[v.bin] ^ vs_mask}));
        push(K_DONE, d + 10, '0, '0);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) begin
                done_core_i = 1'b0;
                sat_i = ~v.sat; unsat_i = ~v.unsat; bkt_lvl_i = ~v.blvl; bkt_bin_i = ~v.bbin;
                exp_sat = v.sat; exp_unsat = v.unsat; exp_blvl = v.blvl; exp_bbin = v.bbin;
                check_latched("verdict");
            end
            if (n == 4 && v.rst_wb) begin
                #2 rst = 1'b1;
                #1;
                check("reset_mid_wb_outputs", 256'(any_out), 256'(0));
                sb.delete();
                exp_sat = 1'b0; exp_unsat = 1'b0; exp_blvl = '0; exp_bbin = '0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
        #1;
        check("scoreboard_drained", 256'(sb.size()), 256'(0));
    endtask

    initial begin
        vecs[0] = '{10'd5,    16'd7,      16'd2,      1'b1, 1'b0, 16'd3,      10'd0,     3,  1'b0, 1'b0, 1'b0};
        vecs[1] = '{10'd9,    16'h1234,   16'h0011,   1'b0, 1'b1, 16'd1,      10'd2,     5,  1'b1, 1'b1, 1'b0};
        vecs[2] = '{10'd1023, 16'hffff,   16'hffff,   1'b1, 1'b0, 16'hffff,   10'h3ff,   1,  1'b0, 1'b0, 1'b1};
        vecs[3] = '{10'd0,    16'd4,      16'd1,      1'b0, 1'b1, 16'h0055,   10'h155,   2,  1'b0, 1'b0, 1'b0};
        vecs[4] = '{10'd682,  16'h8001,   16'h7ffe,   1'b1, 1'b0, 16'h00aa,   10'h2aa,   20, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{10'd5,    16'd9,      16'd3,      1'b0, 1'b0, 16'h0000,   10'h001,   2,  1'b0, 1'b1, 1'b0};
        rst = 1'b1;
        start_bin_i = 1'b0; bin_id_i = '0; load_lvl_i = '0; base_lvl_i = '0;
        done_core_i = 1'b0; sat_i = 1'b0; unsat_i = 1'b0; bkt_lvl_i = '0; bkt_bin_i = '0;
        vs_mask = '0; ls_mask = '0;
        exp_sat = 1'b0; exp_unsat = 1'b0; exp_blvl = '0; exp_bbin = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 256'(any_out), 256'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", 256'(any_out), 256'(0));
        for (int i = 0; i < 6; i++) run_bin(vecs[i]);
        repeat (3) @(negedge clk);
        #1;
        check("final_idle_busy", 256'(busy_o), 256'(0));
        check("final_scoreboard_empty", 256'(sb.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d expected=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bin_load_ctrl.md
# bin_load_ctrl

Sequencer between the global bin store and `sat_engine`. For one bin it loads clauses, var states and lvl states into the engine, then starts the core. It waits for the core to finish, writes the updated clause array and state lists back to the store, and returns the core's verdict to the top-level controller. One bin is processed per `start_bin_i` request.

## Interface
Parameters:
- NUM_CLAUSES, 8, clauses per bin (engine clause-array rows)
- NUM_VARS, 8, variables per bin
- NUM_LVLS, 8, level slots per bin
- WIDTH_CIDX, 3, clause index width, equal to log2(NUM_CLAUSES)
- WIDTH_BIN_ID, 10, bin id width
- WIDTH_LVL, 16, level width
- WIDTH_VAR_STATES, 19, per-var state width
- WIDTH_LVL_STATES, 11, per-level state width

Ports (clock is `clk`, reset is `rst`; one clock, asynchronous active-high reset):
- clk  in  1  clock
- rst  in  1  asynchronous reset, active high
- start_bin_i  in  1  request to process bin; sampled only in IDLE
- bin_id_i  in  WIDTH_BIN_ID  bin to process; captured with start_bin_i
- load_lvl_i  in  WIDTH_LVL  decision level at entry; captured with start_bin_i
- base_lvl_i  in  WIDTH_LVL  base level; captured with start_bin_i
- busy_o  out  1  high whenever not IDLE
- done_bin_o  out  1  one-cycle pulse at the end of writeback
- bin_sat_o, bin_unsat_o  out  1 each  verdict latched from the core
- bkt_lvl_o  out  WIDTH_LVL  latched from the core
- bkt_bin_o  out  WIDTH_BIN_ID  latched from the core
- cmem_rd_o, cmem_wr_o  out  1 each  clause store read/write strobes
- cmem_addr_o  out  WIDTH_BIN_ID+WIDTH_CIDX  {bin_id, clause idx}
- cmem_rdata_i  in  2*NUM_VARS  read data, valid exactly 1 cycle after cmem_rd_o
- cmem_wdata_o  out  2*NUM_VARS  write data
- smem_rd_o, smem_wr_o  out  1 each  state store strobes
- smem_addr_o  out  WIDTH_BIN_ID  bin id
- smem_vs_rdata_i, smem_vs_wdata_o  in/out  WIDTH_VAR_STATES*NUM_VARS  var state list
- smem_ls_rdata_i, smem_ls_wdata_o  in/out  WIDTH_LVL_STATES*NUM_LVLS  lvl state list; read data has 1-cycle latency
- start_core_o  out  1  one-cycle start pulse to the engine
- done_core_i  in  1  engine finished
- sat_i, unsat_i  in  1 each  engine verdict
- bkt_lvl_i  in  WIDTH_LVL  engine backtrack level
- bkt_bin_i  in  WIDTH_BIN_ID  engine backtrack bin
- cur_bin_num_o  out  WIDTH_LVL  zero-extended captured bin id
- load_lvl_o  out  WIDTH_LVL  captured load level
- base_lvl_o  out  WIDTH_LVL  captured base level
- wr_carray_o, rd_carray_o  out  NUM_CLAUSES  one-hot row select, or 0
- clause_o  out  2*NUM_VARS  clause to engine
- clause_i  in  2*NUM_VARS  clause from engine, combinationally valid while rd_carray_o is set
- wr_var_states_o  out  NUM_VARS  all-ones in the state-write cycle, else 0
- var_states_o, var_states_i  out/in  WIDTH_VAR_STATES*NUM_VARS
- wr_lvl_states_o  out  NUM_LVLS  all-ones in the state-write cycle, else 0
- lvl_states_o, lvl_states_i  out/in  WIDTH_LVL_STATES*NUM_LVLS
- base_lvl_en_o  out  1  base level write strobe

## Operation
- States: IDLE, LD_C, LD_S_RD, LD_S_WR, START, RUN, WB_C, WB_S, DONE.
- IDLE:
  - On start_bin_i, capture bin_id, load_lvl and base_lvl.
  - Clear k to 0.
  - Go to LD_C.
- LD_C, NUM_CLAUSES+1 cycles, pipelined:
  - While k<NUM_CLAUSES, assert cmem_rd_o with address {bin,k}.
  - From the second cycle, assert wr_carray_o=1<<(k-1) with clause_o=cmem_rdata_i.
  - Then go to LD_S_RD.
- LD_S_RD: assert smem_rd_o with address bin.
- LD_S_WR:
  - Assert wr_var_states_o and wr_lvl_states_o as all-ones.
  - Drive var/lvl states from smem read data.
  - Assert base_lvl_en_o=1.
- START: start_core_o=1 with load_lvl_o and cur_bin_num_o valid.
- RUN:
  - Wait for done_core_i.
  - On done_core_i, latch sat_i, unsat_i, bkt_lvl_i and bkt_bin_i.
  - Clear k and go to WB_C.
- WB_C, NUM_CLAUSES cycles:
  - rd_carray_o=1<<k.
  - cmem_wr_o=1 with address {bin,k} and cmem_wdata_o=clause_i.
- WB_S: smem_wr_o=1 with wdata taken from var_states_i and lvl_states_i.
- DONE: done_bin_o=1, then return to IDLE.
- Writeback happens for both sat and unsat verdicts.
- Default values: all strobes, one-hot buses and clause_o are 0 outside their active cycles.

## Timing
- Reset values:
  - State is IDLE.
  - Every output is 0, including the latched verdict and the captured bin/levels.
  - No memory strobe is asserted.
- Reset mid-operation: return to IDLE immediately with outputs 0. A partially loaded or written bin is left as-is; the master re-requests it.
- Load latency: start_bin_i sampled at edge 0 → start_core_o high in cycle NUM_CLAUSES+4.
- Completion latency: done_core_i seen in cycle D → done_bin_o high in cycle D+NUM_CLAUSES+2.
- Latched outputs (bin_sat_o, bin_unsat_o, bkt_*_o):
  - Update the cycle after D.
  - Hold until the next done_core_i or reset.
  - Are not cleared by a new start.
- Ignored inputs:
  - start_bin_i while busy.
  - done_core_i outside RUN, including in the START cycle itself.
- k counter: WIDTH_CIDX+1 bits, so that it can reach NUM_CLAUSES without wrap.
- Address: {bin, k[WIDTH_CIDX-1:0]}.

## Test plan
- Load sequence with NUM_CLAUSES=8, bin 5:
  - cmem_rd_o in cycles 1–8 with addresses 40..47.
  - wr_carray_o = 00000001 in cycle 2 through 10000000 in cycle 9, clause_o equal to the store data.
  - smem_rd_o in cycle 10.
  - wr/base_lvl_en_o in cycle 11.
  - start_core_o in cycle 12.
- Writeback: done_core_i at cycle D with sat_i=1, bkt_lvl_i=3 →
  - rd_carray_o one-hot and cmem_wr_o in D+1..D+8.
  - smem_wr_o in D+9.
  - done_bin_o in D+10.
  - bin_sat_o=1 and bkt_lvl_o=3 from D+1.
- Unsat verdict: unsat_i=1, bkt_bin_i=2 → writeback still performed; bin_unsat_o=1 and bkt_bin_o=2.
- Ignored inputs:
  - start_bin_i pulsed during RUN → no effect.
  - done_core_i pulsed during LD_C → no effect.
- Reset asserted in WB_C at k=3 → all outputs 0 at once, state IDLE. A new start_bin_i then completes normally.
- Back-to-back bins: start_bin_i in the cycle after done_bin_o → new load begins, and addresses use the new bin id.
